arr_stream_tx: RTL and testbench

- Parallel-to-stream unloader for the n-bit × m-entry register arrays used across the library.
- On a load request it snapshots an m-entry unpacked array, then transmits the entries one per accepted beat, index 0 first, over a valid/ready stream.
- It is the read-out end of the array register banks: a bank captures words in parallel, and this block drains them serially to a narrow consumer.

---
 rtl/arr_stream_tx.sv | 120 ++++++++++++
 tb/tb_arr_stream_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arr_stream_tx.sv
// arr_stream_tx: snapshots an m-entry array on load_i, then streams the entries
// out one per accepted valid/ready beat, index 0 first. A single-cycle DONE
// state follows the final beat. Every output is decoded from registered state
// only, so ready_i and load_i have no combinational path to any output.
module arr_stream_tx #(
  parameter int unsigned n   = 4,
  parameter int unsigned m   = 16,
  parameter logic [n-1:0] val = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [n-1:0]          arr_i [0:m-1],
  input  logic                  load_i,
  input  logic                  ready_i,
  output logic [n-1:0]          data_o,
  output logic                  valid_o,
  output logic [$clog2(m)-1:0]  idx_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned IW = $clog2(m);
  localparam logic [IW-1:0] LastIdx = IW'(m - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [n-1:0]    buf_q [0:m-1];
  logic [n-1:0]    buf_d [0:m-1];

  logic            at_last;
  logic            beat_ok;

  assign at_last = (idx_q == LastIdx);
  // A beat is only ever offered in SEND, so valid_o reduces to the state.
  assign beat_ok = (state_q == StSend) && ready_i;

  // Next-state: capture on load in IDLE, advance index on accepted beats.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          buf_d   = arr_i;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (beat_ok) begin
          if (at_last) begin
            // Explicit wrap so non-power-of-2 depths never run past m-1.
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StDone: begin
        // load_i is deliberately ignored here; it is re-sampled in IDLE.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and snapshot registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      buf_q   <= '{default: val};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    valid_o = 1'b0;
    data_o  = val;
    idx_o   = idx_q;
    last_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_o = 1'b0;
      end
      StSend: begin
        valid_o = 1'b1;
        data_o  = buf_q[idx_q];
        last_o  = at_last;
        busy_o  = 1'b1;
      end
      StDone: begin
        done_o = 1'b1;
        busy_o = 1'b1;
      end
      default: begin
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arr_stream_tx.sv
// Directed bench for arr_stream_tx: a 4x16 instance (val=4'hA) and an 8x5
// instance (val=0) exercised by a linear sequence of steps with hand-derived
// expectations.
module tb_arr_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: n=4, m=16, val=4'hA
  logic       rst_a, load_a, ready_a;
  logic [3:0] arr_a [0:15];
  logic [3:0] data_a;
  logic [3:0] idx_a;
  logic       valid_a, last_a, busy_a, done_a;

  // Instance B: n=8, m=5, val=0
  logic       rst_b, load_b, ready_b;
  logic [7:0] arr_b [0:4];
  logic [7:0] data_b;
  logic [2:0] idx_b;
  logic       valid_b, last_b, busy_b, done_b;

  arr_stream_tx #(.n(4), .m(16), .val(4'hA)) dut_a (
    .clk_i   (clk),
    .rst_i   (rst_a),
    .arr_i   (arr_a),
    .load_i  (load_a),
    .ready_i (ready_a),
    .data_o  (data_a),
    .valid_o (valid_a),
    .idx_o   (idx_a),
    .last_o  (last_a),
    .busy_o  (busy_a),
    .done_o  (done_a)
  );

  arr_stream_tx #(.n(8), .m(5), .val(8'h00)) dut_b (
    .clk_i   (clk),
    .rst_i   (rst_b),
    .arr_i   (arr_b),
    .load_i  (load_b),
    .ready_i (ready_b),
    .data_o  (data_b),
    .valid_o (valid_b),
    .idx_o   (idx_b),
    .last_o  (last_b),
    .busy_o  (busy_b),
    .done_o  (done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".valid"}, 32'(valid_a), 32'd0);
    chk({tag, ".data"},  32'(data_a),  32'hA);
    chk({tag, ".busy"},  32'(busy_a),  32'd0);
    chk({tag, ".idx"},   32'(idx_a),   32'd0);
    chk({tag, ".last"},  32'(last_a),  32'd0);
    chk({tag, ".done"},  32'(done_a),  32'd0);
  endtask

  task automatic chk_beat_a(input string tag, input int k, input logic [3:0] d);
    chk({tag, ".valid"}, 32'(valid_a), 32'd1);
    chk({tag, ".data"},  32'(data_a),  32'(d));
    chk({tag, ".idx"},   32'(idx_a),   32'(k));
    chk({tag, ".last"},  32'(last_a),  32'(k == 15));
    chk({tag, ".busy"},  32'(busy_a),  32'd1);
    chk({tag, ".done"},  32'(done_a),  32'd0);
  endtask

  task automatic set_arr_a_ramp();
    for (int i = 0; i < 16; i++) arr_a[i] = 4'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_k;
    int cyc;
    logic [7:0] exp_b [0:4];

    rst_a = 1'b0; load_a = 1'b0; ready_a = 1'b0;
    rst_b = 1'b0; load_b = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < 16; i++) arr_a[i] = 4'h0;
    for (int i = 0; i < 5; i++)  arr_b[i] = 8'h00;

    // 1. Reset state, then idle with load low.
    #3;
    chk_idle_a("rst");
    chk("rst_b.data",  32'(data_b),  32'h00);
    chk("rst_b.valid", 32'(valid_b), 32'd0);
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle_a("idle");
    end

    // 2. Full-rate transfer.
    set_arr_a_ramp();
    load_a  = 1'b1;
    ready_a = 1'b1;
    tick();
    load_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_beat_a("full", k, 4'(k));
      tick();
    end
    chk("full.done",       32'(done_a),  32'd1);
    chk("full.done_valid", 32'(valid_a), 32'd0);
    chk("full.done_busy",  32'(busy_a),  32'd1);
    chk("full.done_data",  32'(data_a),  32'hA);
    tick();
    chk_idle_a("full.end");

    // 3. Backpressure with ready pattern 1,0,0 repeating.
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    exp_k = 0;
    cyc   = 0;
    while (exp_k < 16 && cyc < 100) begin
      ready_a = (cyc % 3 == 0);
      chk("bp.valid", 32'(valid_a), 32'd1);
      chk("bp.data",  32'(data_a),  32'(exp_k));
      chk("bp.idx",   32'(idx_a),   32'(exp_k));
      tick();
      if (ready_a) exp_k++;
      cyc++;
    end
    chk("bp.bound", 32'(cyc < 100), 32'd1);
    chk("bp.done",  32'(done_a),    32'd1);
    ready_a = 1'b1;
    tick();
    chk_idle_a("bp.end");

    // 4. Snapshot isolation: arr_i changed and load_i held during SEND.
    set_arr_a_ramp();
    load_a = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) arr_a[i] = 4'hF;
    for (int k = 0; k < 16; k++) begin
      chk_beat_a("iso", k, 4'(k));
      tick();
    end
    chk("iso.done", 32'(done_a), 32'd1);
    tick();
    chk("iso.idle_busy",  32'(busy_a),  32'd0);
    chk("iso.idle_valid", 32'(valid_a), 32'd0);
    tick();
    chk_beat_a("iso.reload", 0, 4'hF);
    load_a = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    chk_idle_a("iso.end");

    // 5. Reset mid-transfer at beat 7.
    set_arr_a_ramp();
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk_beat_a("mid.pre", 7, 4'h7);
    #2;
    rst_a = 1'b0;
    #1;
    chk_idle_a("mid.async");
    tick();
    chk_idle_a("mid.hold");
    rst_a = 1'b1;
    tick();
    chk_idle_a("mid.after");
    for (int i = 0; i < 16; i++) arr_a[i] = 4'(15 - i);
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk_beat_a("mid.new0", 0, 4'hF);
    tick();
    chk_beat_a("mid.new1", 1, 4'hE);

    // 6. Non-power-of-2 depth on instance B.
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55;
    for (int i = 0; i < 5; i++) arr_b[i] = exp_b[i];
    load_b  = 1'b1;
    ready_b = 1'b1;
    tick();
    load_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("np2.valid", 32'(valid_b), 32'd1);
      chk("np2.data",  32'(data_b),  32'(exp_b[k]));
      chk("np2.idx",   32'(idx_b),   32'(k));
      chk("np2.last",  32'(last_b),  32'(k == 4));
      chk("np2.done",  32'(done_b),  32'd0);
      tick();
    end
    chk("np2.done_pulse", 32'(done_b),  32'd1);
    chk("np2.wrap_idx",   32'(idx_b),   32'd0);
    chk("np2.done_valid", 32'(valid_b), 32'd0);
    tick();
    chk("np2.done_once",  32'(done_b),  32'd0);
    chk("np2.idle_busy",  32'(busy_b),  32'd0);
    tick();
    chk("np2.still_idle", 32'(done_b),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
